scan2d_sched: RTL and testbench

- Round-robin scheduler and sequencer for one shared 2D strided address generator, time-shared between two requesters.
- Each requester posts a scan job: base address, x/y strides, x/y limits.
- The block grants one job at a time, runs the x/y scan, and streams one address per beat over a valid/ready interface, tagged with the owner ID.
- It pulses done to the owner when the scan finishes. It sits between the loop-control front end and the memory address port.

---
 rtl/scan2d_if.sv | 38 +++
 rtl/scan2d_sched.sv | 111 +++++++++++
 tb/tb_scan2d_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan2d_if.sv
// Job-post and address-stream bundle for the shared 2D scan sequencer.
// master drives jobs and accepts beats; slave is the scheduler.
interface scan2d_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int XS_W   = 16
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_base;
  logic [2*XS_W-1:0]   req_x_stride;
  logic [2*CNT_W-1:0]  req_x_max;
  logic [2*ADDR_W-1:0] req_y_stride;
  logic [2*CNT_W-1:0]  req_y_max;
  logic                abort;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_id;
  logic                out_last;
  logic [1:0]          done;

  modport master (
    output req_valid, req_base, req_x_stride,
    output req_x_max, req_y_stride, req_y_max,
    output abort, out_ready,
    input  req_ready, out_valid, out_addr,
    input  out_id, out_last, done
  );

  modport slave (
    input  req_valid, req_base, req_x_stride,
    input  req_x_max, req_y_stride, req_y_max,
    input  abort, out_ready,
    output req_ready, out_valid, out_addr,
    output out_id, out_last, done
  );
endinterface

// File: rtl/scan2d_sched.sv
// Round-robin scheduler time-sharing one 2D strided
// address generator between two requesters.
module scan2d_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int XS_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  scan2d_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, ys;
  logic [XS_W-1:0]   xs;
  logic [CNT_W-1:0]  x, y, xm, ym;
  logic              id, last_grant;
  logic [1:0]        done_q;

  logic              g, any, load, beat, last, fin;
  logic [ADDR_W-1:0] sel_base, sel_ys;
  logic [XS_W-1:0]   sel_xs;
  logic [CNT_W-1:0]  sel_xm, sel_ym;

  // Tie goes to whoever was not granted last.
  assign any = |bus.req_valid;
  assign g   = (&bus.req_valid) ? ~last_grant
                                : bus.req_valid[1];

  assign sel_base = g ? bus.req_base[2*ADDR_W-1:ADDR_W]
                      : bus.req_base[ADDR_W-1:0];
  assign sel_ys   = g ? bus.req_y_stride[2*ADDR_W-1:ADDR_W]
                      : bus.req_y_stride[ADDR_W-1:0];
  assign sel_xs   = g ? bus.req_x_stride[2*XS_W-1:XS_W]
                      : bus.req_x_stride[XS_W-1:0];
  assign sel_xm   = g ? bus.req_x_max[2*CNT_W-1:CNT_W]
                      : bus.req_x_max[CNT_W-1:0];
  assign sel_ym   = g ? bus.req_y_max[2*CNT_W-1:CNT_W]
                      : bus.req_y_max[CNT_W-1:0];

  assign last = (x == xm) && (y == ym);
  assign beat = (state == RUN) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: if (any && !rst) begin
        load    = 1'b1;
        state_n = RUN;
      end
      RUN: if (beat && last) begin
        fin     = 1'b1;
        state_n = IDLE;
      end else if (bus.abort) begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      ys         <= '0;
      xs         <= '0;
      x          <= '0;
      y          <= '0;
      xm         <= '0;
      ym         <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      done_q     <= 2'b00;
    end else begin
      done_q <= fin ? (id ? 2'b10 : 2'b01) : 2'b00;
      if (load) begin
        addr       <= sel_base;
        ys         <= sel_ys;
        xs         <= sel_xs;
        xm         <= sel_xm;
        ym         <= sel_ym;
        x          <= '0;
        y          <= '0;
        id         <= g;
        last_grant <= g;
      end else if (beat && !last) begin
        if (x == xm) begin
          x    <= '0;
          y    <= y + CNT_W'(1);
          addr <= addr + ys;
        end else begin
          x    <= x + CNT_W'(1);
          addr <= addr + {{(ADDR_W-XS_W){1'b0}}, xs};
        end
      end
    end
  end

  assign bus.req_ready = load ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign bus.out_valid = (state == RUN);
  assign bus.out_last  = (state == RUN) && last;
  assign bus.out_addr  = addr;
  assign bus.out_id    = id;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_scan2d_sched.sv
// Bench for scan2d_sched: directed scenarios plus a
// randomized job mix against a closed-form address model.
module tb_scan2d_sched;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam int XW = 16;

  typedef struct {
    logic [31:0] base;
    logic [15:0] xs;
    logic [31:0] xm;
    logic [31:0] ys;
    logic [31:0] ym;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan2d_if #(.ADDR_W(AW), .CNT_W(CW), .XS_W(XW)) bus ();

  scan2d_sched #(.ADDR_W(AW), .CNT_W(CW), .XS_W(XW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  bit keep = 0;
  int rdy_mode = 0;

  logic [31:0] b_addr[$];
  bit          b_id[$];
  bit          b_last[$];
  int          b_cyc[$];
  bit          d_id[$];
  int          d_cyc[$];
  logic [1:0]  g_raw[$];
  logic [1:0]  g_vld[$];
  int          g_cyc[$];
  bit          v_q[$];
  logic [31:0] a_q[$];

  // Address of beat k: rows advance by xm*xs + ys.
  function automatic logic [31:0] ref_addr(job_t j, int k);
    logic [31:0] xx, yy, xs32;
    xs32 = {16'h0, j.xs};
    xx = 32'(k) % (j.xm + 1);
    yy = 32'(k) / (j.xm + 1);
    return j.base + yy * (j.xm * xs32 + j.ys) + xx * xs32;
  endfunction

  function automatic int nbeats(job_t j);
    return int'((j.xm + 1) * (j.ym + 1));
  endfunction

  task automatic set_job(input int i, input job_t j);
    bus.req_base[i*AW +: AW]     = j.base;
    bus.req_x_stride[i*XW +: XW] = j.xs;
    bus.req_x_max[i*CW +: CW]    = j.xm;
    bus.req_y_stride[i*AW +: AW] = j.ys;
    bus.req_y_max[i*CW +: CW]    = j.ym;
  endtask

  task automatic clear_logs();
    b_addr.delete(); b_id.delete(); b_last.delete();
    b_cyc.delete(); d_id.delete(); d_cyc.delete();
    g_raw.delete(); g_vld.delete(); g_cyc.delete();
    v_q.delete(); a_q.delete();
  endtask

  // One clock: observe at negedge, update inputs after posedge.
  task automatic tick();
    logic [1:0] acc;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      b_addr.push_back(bus.out_addr);
      b_id.push_back(bus.out_id);
      b_last.push_back(bus.out_last);
      b_cyc.push_back(cyc);
    end
    for (int i = 0; i < 2; i++)
      if (bus.done[i]) begin
        d_id.push_back(i[0]);
        d_cyc.push_back(cyc);
      end
    if (bus.req_ready != 2'b00) begin
      g_raw.push_back(bus.req_ready);
      g_vld.push_back(bus.req_valid);
      g_cyc.push_back(cyc);
    end
    v_q.push_back(bus.out_valid);
    a_q.push_back(bus.out_addr);
    acc = bus.req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (!keep) bus.req_valid = bus.req_valid & ~acc;
    if (rdy_mode == 1) bus.out_ready = ($urandom % 4) != 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic job_t plan1();
    job_t j;
    j.base = 32'h100; j.xs = 16'd4; j.xm = 32'd2;
    j.ys = 32'h10; j.ym = 32'd1;
    return j;
  endfunction

  task automatic test_reset();
    job_t j;
    j = plan1();
    set_job(0, j);
    set_job(1, j);
    bus.req_valid = 2'b11;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    vec++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    vec++; if (bus.req_ready !== 2'b00) begin bad++;
      $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    vec++; if (bus.done !== 2'b00) begin bad++;
      $display("FAIL reset_done got %b want 00", bus.done); end
    vec++; if (bus.out_addr !== 32'h0) begin bad++;
      $display("FAIL reset_addr got %h want 0", bus.out_addr); end
    vec++; if (bus.out_id !== 1'b0 || bus.out_last !== 1'b0) begin bad++;
      $display("FAIL reset_id_last got %b%b want 00", bus.out_id, bus.out_last); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] e[6];
    int n;
    e = '{32'h100, 32'h104, 32'h108, 32'h118, 32'h11C, 32'h120};
    clear_logs();
    set_job(0, plan1());
    bus.req_valid = 2'b01;
    rdy_mode = 0; bus.out_ready = 1'b1;
    n = 0;
    while (d_id.size() == 0 && n < 40) begin tick(); n++; end
    repeat (3) tick();
    vec++; if (d_id.size() != 1) begin bad++;
      $display("FAIL single_done_count got %0d want 1", d_id.size()); end
    vec++; if (b_addr.size() != 6) begin bad++;
      $display("FAIL single_beats got %0d want 6", b_addr.size()); end
    for (int k = 0; k < 6 && k < b_addr.size(); k++) begin
      vec++;
      if (b_addr[k] !== e[k] || b_id[k] !== 1'b0 || b_last[k] !== (k == 5)
          || b_cyc[k] != b_cyc[0] + k) begin bad++;
        $display("FAIL single_beat[%0d] got %h id%b last%b want %h id0 last%0d",
                 k, b_addr[k], b_id[k], b_last[k], e[k], k == 5); end
    end
    vec++; if (g_raw.size() != 1 || g_raw[0] !== 2'b01) begin bad++;
      $display("FAIL single_req_ready got %0d grants want 1 of 01", g_raw.size()); end
    if (g_raw.size() == 1 && b_addr.size() == 6 && d_id.size() == 1) begin
      vec++; if (b_cyc[0] != g_cyc[0] + 1) begin bad++;
        $display("FAIL single_latency got %0d want %0d", b_cyc[0], g_cyc[0] + 1); end
      vec++; if (d_id[0] !== 1'b0 || d_cyc[0] != b_cyc[5] + 1) begin bad++;
        $display("FAIL single_done got id%b cyc%0d want id0 cyc%0d",
                 d_id[0], d_cyc[0], b_cyc[5] + 1); end
    end
  endtask

  task automatic test_tie();
    job_t ja, jb;
    int n;
    do_reset();
    clear_logs();
    ja.base = $urandom; ja.xs = 16'($urandom); ja.xm = 0;
    ja.ys = $urandom; ja.ym = 0;
    jb.base = $urandom; jb.xs = 16'($urandom); jb.xm = 0;
    jb.ys = $urandom; jb.ym = 0;
    set_job(0, ja); set_job(1, jb);
    bus.req_valid = 2'b11;
    keep = 1;
    n = 0;
    while (g_raw.size() < 4 && n < 40) begin tick(); n++; end
    bus.req_valid = 2'b00;
    keep = 0;
    while (d_id.size() < 4 && n < 60) begin tick(); n++; end
    repeat (2) tick();
    vec++; if (g_raw.size() != 4 || d_id.size() != 4 || b_addr.size() != 4) begin bad++;
      $display("FAIL tie_counts got g%0d d%0d b%0d want 4 4 4",
               g_raw.size(), d_id.size(), b_addr.size()); end
    for (int k = 0; k < 4 && k < g_raw.size() && k < d_id.size()
         && k < b_addr.size(); k++) begin
      vec++;
      if (g_raw[k] !== ((k % 2) ? 2'b10 : 2'b01) || d_id[k] !== k[0]
          || b_last[k] !== 1'b1 || b_id[k] !== k[0]
          || b_addr[k] !== ((k % 2) ? jb.base : ja.base)) begin bad++;
        $display("FAIL tie_job[%0d] got grant %b done %b last %b addr %h want id %0d",
                 k, g_raw[k], d_id[k], b_last[k], b_addr[k], k % 2); end
      if (k > 0) begin
        vec++; if (g_cyc[k] != d_cyc[k-1]) begin bad++;
          $display("FAIL tie_gap[%0d] got grant cyc %0d want %0d",
                   k, g_cyc[k], d_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e[6];
    int n, s;
    e = '{32'h100, 32'h104, 32'h108, 32'h118, 32'h11C, 32'h120};
    clear_logs();
    set_job(0, plan1());
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    n = 0;
    while (b_addr.size() < 1 && n < 20) begin tick(); n++; end
    bus.out_ready = 1'b0;
    s = v_q.size();
    repeat (3) tick();
    bus.out_ready = 1'b1;
    while (d_id.size() == 0 && n < 40) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      vec++; if (v_q[s+k] !== 1'b1 || a_q[s+k] !== 32'h104) begin bad++;
        $display("FAIL bp_hold[%0d] got v%b %h want v1 00000104",
                 k, v_q[s+k], a_q[s+k]); end
    end
    vec++; if (b_addr.size() != 6 || d_id.size() != 1) begin bad++;
      $display("FAIL bp_counts got b%0d d%0d want 6 1", b_addr.size(), d_id.size()); end
    for (int k = 0; k < 6 && k < b_addr.size(); k++) begin
      vec++; if (b_addr[k] !== e[k] || b_last[k] !== (k == 5)) begin bad++;
        $display("FAIL bp_beat[%0d] got %h last%b want %h", k, b_addr[k], b_last[k], e[k]); end
    end
    if (b_addr.size() >= 2) begin
      vec++; if (b_cyc[1] != b_cyc[0] + 4) begin bad++;
        $display("FAIL bp_timing got %0d want %0d", b_cyc[1], b_cyc[0] + 4); end
    end
  endtask

  task automatic test_wrap();
    job_t j;
    int n;
    clear_logs();
    j.base = 32'hFFFF_FFF8; j.xs = 16'd8; j.xm = 1;
    j.ys = $urandom; j.ym = 0;
    set_job(1, j);
    bus.req_valid = 2'b10;
    n = 0;
    while (d_id.size() == 0 && n < 20) begin tick(); n++; end
    vec++; if (b_addr.size() != 2 || d_id.size() != 1) begin bad++;
      $display("FAIL wrap_counts got b%0d d%0d want 2 1", b_addr.size(), d_id.size()); end
    if (b_addr.size() == 2 && d_id.size() == 1) begin
      vec++; if (b_addr[0] !== 32'hFFFF_FFF8 || b_addr[1] !== 32'h0) begin bad++;
        $display("FAIL wrap_addr got %h %h want fffffff8 00000000", b_addr[0], b_addr[1]); end
      vec++; if (b_id[0] !== 1'b1 || b_id[1] !== 1'b1 || b_last[0] !== 1'b0
                 || b_last[1] !== 1'b1 || d_id[0] !== 1'b1) begin bad++;
        $display("FAIL wrap_flags got id%b%b last%b%b done%b want 11 01 1",
                 b_id[0], b_id[1], b_last[0], b_last[1], d_id[0]); end
    end
  endtask

  task automatic test_abort();
    job_t jb;
    int n, s, ab, nb;
    clear_logs();
    set_job(0, plan1());
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    n = 0;
    while (b_addr.size() < 2 && n < 20) begin tick(); n++; end
    jb.base = $urandom; jb.xs = 16'($urandom); jb.xm = $urandom % 3;
    jb.ys = $urandom; jb.ym = $urandom % 3;
    nb = nbeats(jb);
    set_job(1, jb);
    bus.req_valid = 2'b10;
    bus.abort = 1'b1;
    bus.out_ready = 1'b0;
    s = v_q.size();
    ab = cyc;
    tick();
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    while (d_id.size() == 0 && n < 60) begin tick(); n++; end
    repeat (2) tick();
    vec++; if (v_q[s] !== 1'b1 || v_q[s+1] !== 1'b0) begin bad++;
      $display("FAIL abort_valid got %b%b want 10", v_q[s], v_q[s+1]); end
    vec++; if (g_raw.size() != 2 || g_raw[1] !== 2'b10 || g_cyc[1] != ab + 1) begin bad++;
      $display("FAIL abort_regrant got %0d grants last %b at %0d want 10 at %0d",
               g_raw.size(), g_raw[g_raw.size()-1], g_cyc[g_cyc.size()-1], ab + 1); end
    vec++; if (d_id.size() != 1 || d_id[0] !== 1'b1) begin bad++;
      $display("FAIL abort_done got %0d pulses want only done[1]", d_id.size()); end
    vec++; if (b_addr.size() != 2 + nb) begin bad++;
      $display("FAIL abort_beats got %0d want %0d", b_addr.size(), 2 + nb); end
    for (int k = 0; k < nb && k + 2 < b_addr.size(); k++) begin
      vec++; if (b_addr[k+2] !== ref_addr(jb, k) || b_id[k+2] !== 1'b1
                 || b_last[k+2] !== (k == nb - 1)) begin bad++;
        $display("FAIL abort_job1[%0d] got %h want %h", k, b_addr[k+2], ref_addr(jb, k)); end
    end
  endtask

  task automatic test_random();
    localparam int NJ = 24;
    job_t jq0[$], jq1[$], j;
    logic [31:0] ea[$];
    bit ei[$], el[$];
    int p0, p1, i0, i1, n, m;
    bit m_last, eg;
    do_reset();
    clear_logs();
    for (int k = 0; k < NJ; k++) begin
      j.base = $urandom; j.xs = 16'($urandom); j.xm = $urandom % 5;
      j.ys = $urandom; j.ym = $urandom % 4;
      if ($urandom % 2) jq1.push_back(j); else jq0.push_back(j);
    end
    p0 = 0; p1 = 0; n = 0;
    rdy_mode = 1;
    while (d_id.size() < NJ && n < 5000) begin
      if (!bus.req_valid[0] && p0 < jq0.size() && $urandom % 3 == 0) begin
        set_job(0, jq0[p0]); p0++; bus.req_valid[0] = 1'b1;
      end
      if (!bus.req_valid[1] && p1 < jq1.size() && $urandom % 3 == 0) begin
        set_job(1, jq1[p1]); p1++; bus.req_valid[1] = 1'b1;
      end
      tick();
      n++;
    end
    rdy_mode = 0;
    bus.out_ready = 1'b1;
    vec++; if (d_id.size() != NJ || g_raw.size() != NJ) begin bad++;
      $display("FAIL rand_jobs got d%0d g%0d want %0d", d_id.size(), g_raw.size(), NJ); end
    m_last = 1'b1; i0 = 0; i1 = 0;
    for (int k = 0; k < g_raw.size(); k++) begin
      eg = (g_vld[k] == 2'b11) ? ~m_last : g_vld[k][1];
      m_last = eg;
      vec++; if (g_raw[k] !== (eg ? 2'b10 : 2'b01)) begin bad++;
        $display("FAIL rand_grant[%0d] got %b want id %0d", k, g_raw[k], eg); end
      if (k < d_id.size()) begin
        vec++; if (d_id[k] !== eg) begin bad++;
          $display("FAIL rand_done[%0d] got %b want %b", k, d_id[k], eg); end
      end
      if (eg && i1 < jq1.size()) begin j = jq1[i1]; i1++; end
      else if (!eg && i0 < jq0.size()) begin j = jq0[i0]; i0++; end
      m = nbeats(j);
      for (int b = 0; b < m; b++) begin
        ea.push_back(ref_addr(j, b));
        ei.push_back(eg);
        el.push_back(b == m - 1);
      end
    end
    vec++; if (b_addr.size() != ea.size()) begin bad++;
      $display("FAIL rand_beats got %0d want %0d", b_addr.size(), ea.size()); end
    for (int k = 0; k < ea.size() && k < b_addr.size(); k++) begin
      vec++; if (b_addr[k] !== ea[k] || b_id[k] !== ei[k] || b_last[k] !== el[k]) begin bad++;
        $display("FAIL rand_beat[%0d] got %h id%b last%b want %h id%b last%b",
                 k, b_addr[k], b_id[k], b_last[k], ea[k], ei[k], el[k]); end
    end
  endtask

  task automatic test_async_reset();
    job_t jb;
    int n;
    clear_logs();
    set_job(0, plan1());
    bus.req_valid = 2'b01;
    n = 0;
    while (b_addr.size() < 2 && n < 20) begin tick(); n++; end
    #2;
    vec++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL areset_pre got %b want 1", bus.out_valid); end
    jb.base = $urandom; jb.xs = 16'($urandom); jb.xm = 1;
    jb.ys = $urandom; jb.ym = 0;
    set_job(1, jb);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    vec++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 2'b00
               || bus.out_addr !== 32'h0 || bus.out_last !== 1'b0) begin bad++;
      $display("FAIL areset_now got v%b rr%b a%h l%b want 0 00 0 0",
               bus.out_valid, bus.req_ready, bus.out_addr, bus.out_last); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    while (d_id.size() < 2 && n < 80) begin tick(); n++; end
    vec++; if (g_raw.size() != 3 || g_raw[1] !== 2'b01 || g_raw[2] !== 2'b10) begin bad++;
      $display("FAIL areset_grant got %0d grants want 01 then 10 after reset", g_raw.size()); end
    vec++; if (d_id.size() != 2 || d_id[0] !== 1'b0 || d_id[1] !== 1'b1) begin bad++;
      $display("FAIL areset_done got %0d pulses want done0 then done1", d_id.size()); end
    vec++; if (b_addr.size() != 10 || b_addr[2] !== 32'h100
               || b_addr[8] !== jb.base) begin bad++;
      $display("FAIL areset_beats got %0d beats want 10 restarting at 100", b_addr.size()); end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_base = '0;
    bus.req_x_stride = '0;
    bus.req_x_max = '0;
    bus.req_y_stride = '0;
    bus.req_y_max = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_wrap();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
